// File: rtl/dst_stream.sv
// rtl/dst_stream.sv - output-buffer reader streaming words out through a 2-entry skid FIFO
// Optional ReLU on buffered words is compiled in with `define DST_RELU_EN.
module dst_stream #(
    parameter int DW = 32,
    parameter int AW = 12
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [AW-1:0] ds,
    output logic          rd_en,
    output logic [AW-1:0] rd_addr,
    input  logic [DW-1:0] rd_data,
    output logic          m_valid,
    input  logic          m_ready,
    output logic [DW-1:0] m_data,
    output logic          m_last,
    output logic          busy,
    output logic          done
);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

    state_t        state;
    logic [AW-1:0] ds_q;
    logic [AW-1:0] addr_q;
    logic          in_flight;
    logic          in_flight_last;
    logic [1:0]    count;
    logic [DW-1:0] fifo_data [2];
    logic [1:0]    fifo_last;
    logic          wr_ptr;
    logic          rd_ptr;
    logic          done_q;
    logic          pop;
    logic          push;
    logic          issue;
    logic [2:0]    credit;
    logic [DW-1:0] wr_word;

    assign pop    = m_valid & m_ready;
    assign push   = in_flight;
    // A new read lands one cycle later, so it may only go out if the slot will be free by then.
    assign credit = {1'b0, count} + {2'b0, in_flight} - {2'b0, pop};
    assign issue  = (state == RUN) && (credit < 3'd2);

`ifdef DST_RELU_EN
    assign wr_word = rd_data[DW-1] ? '0 : rd_data;
`else
    assign wr_word = rd_data;
`endif

    assign rd_en   = issue;
    assign rd_addr = addr_q;
    assign m_valid = (count != 2'd0);
    assign m_data  = fifo_data[rd_ptr];
    assign m_last  = m_valid & fifo_last[rd_ptr];
    assign busy    = (state != IDLE);
    assign done    = done_q;

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_data[wr_ptr] <= wr_word;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state          <= IDLE;
            ds_q           <= '0;
            addr_q         <= '0;
            in_flight      <= 1'b0;
            in_flight_last <= 1'b0;
            count          <= 2'd0;
            fifo_last      <= 2'b00;
            wr_ptr         <= 1'b0;
            rd_ptr         <= 1'b0;
            done_q         <= 1'b0;
        end else begin
            done_q         <= 1'b0;
            in_flight      <= issue;
            in_flight_last <= issue && (addr_q == ds_q);
            count          <= count + {1'b0, push} - {1'b0, pop};
            if (push) begin
                fifo_last[wr_ptr] <= in_flight_last;
                wr_ptr            <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            case (state)
                IDLE: begin
                    if (start) begin
                        ds_q   <= ds;
                        addr_q <= '0;
                        state  <= RUN;
                    end
                end
                RUN: begin
                    // The address holds at ds after the final read so a full-range ds never wraps.
                    if (issue) begin
                        if (addr_q == ds_q) begin
                            state <= DRAIN;
                        end else begin
                            addr_q <= addr_q + 1'b1;
                        end
                    end
                end
                DRAIN: begin
                    if (pop && fifo_last[rd_ptr]) begin
                        state  <= IDLE;
                        done_q <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dst_stream.sv
// tb/tb_dst_stream.sv - directed, table-driven bench for dst_stream
module tb_dst_stream;

    logic        clk;
    logic        rst;
    logic        start;
    logic [11:0] ds;
    logic        rd_en;
    logic [11:0] rd_addr;
    logic [31:0] rd_data;
    logic        m_valid;
    logic        m_ready;
    logic [31:0] m_data;
    logic        m_last;
    logic        busy;
    logic        done;

    int total;
    int bad;
    logic [31:0] mem [4096];
    logic [31:0] beat0;

    typedef struct {
        int         ds_v;
        logic [3:0] pat;
        int         exp_done;
        int         poke_n;
    } vec_t;

    vec_t vecs [5];

    dst_stream #(.DW(32), .AW(12)) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .ds      (ds),
        .rd_en   (rd_en),
        .rd_addr (rd_addr),
        .rd_data (rd_data),
        .m_valid (m_valid),
        .m_ready (m_ready),
        .m_data  (m_data),
        .m_last  (m_last),
        .busy    (busy),
        .done    (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (rd_en) rd_data <= mem[rd_addr];
    end

    function automatic logic [31:0] model(input int a);
        logic [31:0] w;
        w = mem[a];
`ifdef DST_RELU_EN
        if (w[31]) w = 32'h0;
`endif
        return w;
    endfunction

    task automatic chk(input string nm, input longint got, input longint exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", nm, got, exp);
        end
    endtask

    // Runs one transfer. m_ready in cycle n after the start edge is pat[(n-1)%4].
    // poke_n>0 pulses start with ds=0 in that cycle; chain_ds>=0 raises start in the done cycle.
    task automatic run_xfer(input int ds_v, input logic [3:0] pat, input int exp_done,
                            input int poke_n, input bit launch, input int chain_ds, input string nm);
        int n, issued, accepted, data_bad, lasts, last_idx, first_valid, done_at;
        int busy_at_done, proto_bad, max_addr, budget;
        bit prev_stall;
        logic [31:0] prev_data;
        logic prev_last;
        n = 0; issued = 0; accepted = 0; data_bad = 0; lasts = 0; last_idx = -1;
        first_valid = 0; done_at = 0; busy_at_done = 1; proto_bad = 0; max_addr = -1;
        prev_stall = 0; prev_data = 0; prev_last = 0;
        budget = 4 * (ds_v + 1) + 20;
        if (launch) begin
            start = 1'b1;
            ds = 12'(ds_v);
        end
        @(posedge clk);
        #1;
        start = 1'b0;
        n = 1;
        m_ready = pat[0];
        while (n <= budget) begin
            @(negedge clk);
            if (rd_en) begin
                if (int'(rd_addr) != issued) proto_bad++;
                if (int'(rd_addr) > max_addr) max_addr = int'(rd_addr);
                issued++;
            end
            if (prev_stall && (!m_valid || m_data !== prev_data || m_last !== prev_last)) proto_bad++;
            if (m_valid && first_valid == 0) first_valid = n;
            if (m_valid && m_ready) begin
                if (accepted == 0) beat0 = m_data;
                if (m_data !== model(accepted)) data_bad++;
                if (m_last) begin
                    lasts++;
                    last_idx = accepted;
                end
                accepted++;
            end
            if (issued - accepted > 2) proto_bad++;
            prev_stall = m_valid && !m_ready;
            prev_data = m_data;
            prev_last = m_last;
            if (done) begin
                done_at = n;
                busy_at_done = busy;
                if (chain_ds >= 0) begin
                    start = 1'b1;
                    ds = 12'(chain_ds);
                end
                break;
            end
            @(posedge clk);
            #1;
            start = 1'b0;
            n++;
            m_ready = pat[(n - 1) % 4];
            if (n == poke_n) begin
                start = 1'b1;
                ds = 12'd0;
            end
        end
        if (done_at == 0) $display("FAIL %s timeout: no done within %0d cycles", nm, budget);
        chk({nm, " beats"}, accepted, ds_v + 1);
        chk({nm, " data_errs"}, data_bad, 0);
        chk({nm, " last_count"}, lasts, 1);
        chk({nm, " last_index"}, last_idx, ds_v);
        chk({nm, " first_valid_cycle"}, first_valid, 3);
        if (exp_done != 0) chk({nm, " done_cycle"}, done_at, exp_done);
        else chk({nm, " done_seen"}, done_at != 0, 1);
        chk({nm, " busy_at_done"}, busy_at_done, 0);
        chk({nm, " protocol_errs"}, proto_bad, 0);
        chk({nm, " max_addr"}, max_addr, ds_v);
    endtask

    initial begin
        total = 0;
        bad = 0;
        beat0 = 0;
        rd_data = 0;
        for (int i = 0; i < 4096; i++) mem[i] = 32'(i + 1);
        vecs[0] = '{ds_v: 3, pat: 4'b1111, exp_done: 7,  poke_n: 0};
        vecs[1] = '{ds_v: 0, pat: 4'b1111, exp_done: 4,  poke_n: 0};
        vecs[2] = '{ds_v: 7, pat: 4'b1001, exp_done: 0,  poke_n: 0};
        vecs[3] = '{ds_v: 5, pat: 4'b1010, exp_done: 0,  poke_n: 0};
        vecs[4] = '{ds_v: 6, pat: 4'b1111, exp_done: 10, poke_n: 3};

        rst = 1'b0;
        start = 1'b0;
        ds = 12'd0;
        m_ready = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset rd_en", rd_en, 0);
        chk("reset m_valid", m_valid, 0);
        chk("reset m_last", m_last, 0);
        chk("reset busy", busy, 0);
        chk("reset done", done, 0);
        chk("reset rd_addr", rd_addr, 0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;

        for (int v = 0; v < 5; v++) begin
            run_xfer(vecs[v].ds_v, vecs[v].pat, vecs[v].exp_done, vecs[v].poke_n, 1'b1, -1,
                     $sformatf("vec%0d", v));
            repeat (2) @(posedge clk);
            #1;
        end

        // back-to-back: second start lands in the done cycle of the first
        run_xfer(2, 4'b1111, 6, 0, 1'b1, 3, "chain_a");
        run_xfer(3, 4'b1111, 7, 0, 1'b0, -1, "chain_b");
        repeat (2) @(posedge clk);
        #1;

        // reset pulse after the second beat of a ds=9 transfer
        begin
            int valids;
            start = 1'b1;
            ds = 12'd9;
            m_ready = 1'b1;
            @(posedge clk);
            #1;
            start = 1'b0;
            repeat (4) @(posedge clk);
            #1;
            rst = 1'b0;
            @(posedge clk);
            #1;
            rst = 1'b1;
            @(negedge clk);
            chk("midrst rd_en", rd_en, 0);
            chk("midrst m_valid", m_valid, 0);
            chk("midrst m_last", m_last, 0);
            chk("midrst busy", busy, 0);
            chk("midrst done", done, 0);
            chk("midrst rd_addr", rd_addr, 0);
            valids = 0;
            for (int c = 0; c < 10; c++) begin
                @(negedge clk);
                if (m_valid || rd_en || busy) valids++;
            end
            chk("midrst quiet", valids, 0);
            @(posedge clk);
            #1;
            run_xfer(2, 4'b1111, 6, 0, 1'b1, -1, "after_rst");
            repeat (2) @(posedge clk);
            #1;
        end

        // ReLU handling of a negative word
        mem[0] = 32'h8000_0001;
        mem[1] = 32'h0000_0005;
        run_xfer(1, 4'b1111, 5, 0, 1'b1, -1, "relu");
`ifdef DST_RELU_EN
        chk("relu beat0", beat0, 32'h0000_0000);
`else
        chk("relu beat0", beat0, 32'h8000_0001);
`endif
        mem[0] = 32'd1;
        mem[1] = 32'd2;
        repeat (2) @(posedge clk);
        #1;

        run_xfer(4095, 4'b1111, 4099, 0, 1'b1, -1, "max");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
